// File: rtl/eth_rx_frame_filter.sv
// eth_rx_frame_filter
//   Ethernet RX header filter on the MAC nibble stream (eth_tx_clk_i domain).
//   Input nibbles arrive low nibble first, with preamble and CRC already removed.
//   The 14-byte header (28 nibbles) is checked and stripped. Payload nibbles of
//   accepted frames are forwarded with exactly one clock of latency. Mismatching
//   frames and runts are dropped silently and counted.
//
//   Optional feature: define ETH_RX_MAC_FILTER_EN to also check the destination
//   MAC (station address or broadcast). Without it, any destination is accepted.
//
// Ports
//   clk        stream clock (eth_tx_clk_i)
//   rst        asynchronous, active-high reset
//   i_vld      input nibble valid, no backpressure
//   i_eof      last nibble of frame, sampled with i_vld only
//   i_dat      input nibble
//   o_vld      payload nibble valid
//   o_eof      last payload nibble of an accepted frame
//   o_dat      payload nibble
//   frame_cnt  accepted frames, saturating
//   drop_cnt   dropped frames (mismatch or runt), saturating
//
// state   | meaning
// --------+-----------------------------------------------------------
// HDR     | counting/checking header nibbles 0..27
// PAYLOAD | header accepted, forwarding nibbles until eof
// DISCARD | header rejected, swallowing nibbles until eof

module eth_rx_frame_filter #(
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic             i_eof,
    input  logic [3:0]       i_dat,
    output logic             o_vld,
    output logic             o_eof,
    output logic [3:0]       o_dat,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {HDR, PAYLOAD, DISCARD} state_t;

    state_t     state, state_nxt;
    logic [4:0] nib_cnt, nib_cnt_nxt;
    logic       mismatch, mismatch_nxt;
    logic [3:0] et_exp;
    logic       et_bad_now;
    logic       hdr_ok;
    logic       pay_vld;
    logic       inc_frame, inc_drop;

    // EtherType travels MSB byte first, each byte low nibble first.
    always_comb begin
        et_exp = 4'h0;
        case (nib_cnt)
            5'd24:   et_exp = ETHERTYPE[11:8];
            5'd25:   et_exp = ETHERTYPE[15:12];
            5'd26:   et_exp = ETHERTYPE[3:0];
            5'd27:   et_exp = ETHERTYPE[7:4];
            default: et_exp = 4'h0;
        endcase
    end

    assign et_bad_now = (nib_cnt >= 5'd24) && (i_dat != et_exp);

`ifdef ETH_RX_MAC_FILTER_EN
    // Station-address and broadcast matches are tracked separately so that
    // either one can satisfy the destination check.
    logic       mac_mis, mac_mis_nxt;
    logic       not_bcast, not_bcast_nxt;
    logic [7:0] mac_byte;
    logic [3:0] mac_exp;
    logic       mac_chk, mac_bad_now, bc_bad_now;

    always_comb begin
        mac_byte = 8'h00;
        case (nib_cnt[4:1])
            4'd0:    mac_byte = MAC_ADDR[47:40];
            4'd1:    mac_byte = MAC_ADDR[39:32];
            4'd2:    mac_byte = MAC_ADDR[31:24];
            4'd3:    mac_byte = MAC_ADDR[23:16];
            4'd4:    mac_byte = MAC_ADDR[15:8];
            4'd5:    mac_byte = MAC_ADDR[7:0];
            default: mac_byte = 8'h00;
        endcase
    end

    assign mac_exp     = nib_cnt[0] ? mac_byte[7:4] : mac_byte[3:0];
    assign mac_chk     = (nib_cnt < 5'd12);
    assign mac_bad_now = mac_chk && (i_dat != mac_exp);
    assign bc_bad_now  = mac_chk && (i_dat != 4'hF);
    assign hdr_ok      = !(mismatch || et_bad_now) &&
                         (!(mac_mis || mac_bad_now) || !(not_bcast || bc_bad_now));
`else
    logic unused_mac;
    assign unused_mac = ^MAC_ADDR;
    assign hdr_ok     = !(mismatch || et_bad_now);
`endif

    always_comb begin
        state_nxt    = state;
        nib_cnt_nxt  = nib_cnt;
        mismatch_nxt = mismatch;
`ifdef ETH_RX_MAC_FILTER_EN
        mac_mis_nxt   = mac_mis;
        not_bcast_nxt = not_bcast;
`endif
        pay_vld   = 1'b0;
        inc_frame = 1'b0;
        inc_drop  = 1'b0;
        if (i_vld) begin
            case (state)
                HDR: begin
                    nib_cnt_nxt  = nib_cnt + 5'd1;
                    mismatch_nxt = mismatch | et_bad_now;
`ifdef ETH_RX_MAC_FILTER_EN
                    mac_mis_nxt   = mac_mis | mac_bad_now;
                    not_bcast_nxt = not_bcast | bc_bad_now;
`endif
                    // eof anywhere in the header, including nibble 27, is a runt
                    if (i_eof || nib_cnt == 5'd27) begin
                        nib_cnt_nxt  = 5'd0;
                        mismatch_nxt = 1'b0;
`ifdef ETH_RX_MAC_FILTER_EN
                        mac_mis_nxt   = 1'b0;
                        not_bcast_nxt = 1'b0;
`endif
                        if (i_eof)
                            inc_drop = 1'b1;
                        else
                            state_nxt = hdr_ok ? PAYLOAD : DISCARD;
                    end
                end
                PAYLOAD: begin
                    pay_vld = 1'b1;
                    if (i_eof) begin
                        inc_frame = 1'b1;
                        state_nxt = HDR;
                    end
                end
                DISCARD: begin
                    if (i_eof) begin
                        inc_drop  = 1'b1;
                        state_nxt = HDR;
                    end
                end
                default: state_nxt = HDR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HDR;
            nib_cnt   <= 5'd0;
            mismatch  <= 1'b0;
            o_vld     <= 1'b0;
            o_eof     <= 1'b0;
            o_dat     <= 4'h0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            nib_cnt  <= nib_cnt_nxt;
            mismatch <= mismatch_nxt;
            o_vld    <= pay_vld;
            o_eof    <= pay_vld & i_eof;
            o_dat    <= pay_vld ? i_dat : 4'h0;
            if (inc_frame && frame_cnt != '1)
                frame_cnt <= frame_cnt + 1'b1;
            if (inc_drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

`ifdef ETH_RX_MAC_FILTER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_mis   <= 1'b0;
            not_bcast <= 1'b0;
        end else begin
            mac_mis   <= mac_mis_nxt;
            not_bcast <= not_bcast_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
module tb_eth_rx_frame_filter;

    localparam logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST    = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MAC_BAD  = 48'h02_00_00_00_00_02;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_vld = 1'b0;
    logic        i_eof = 1'b0;
    logic [3:0]  i_dat = 4'h0;
    logic        o_vld, o_eof;
    logic [3:0]  o_dat;
    logic [15:0] frame_cnt, drop_cnt;
    logic        s_o_vld, s_o_eof;
    logic [3:0]  s_o_dat;
    logic [1:0]  s_frame_cnt, s_drop_cnt;

    eth_rx_frame_filter dut (
        .clk(clk), .rst(rst), .i_vld(i_vld), .i_eof(i_eof), .i_dat(i_dat),
        .o_vld(o_vld), .o_eof(o_eof), .o_dat(o_dat),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    eth_rx_frame_filter #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .i_vld(i_vld), .i_eof(i_eof), .i_dat(i_dat),
        .o_vld(s_o_vld), .o_eof(s_o_eof), .o_dat(s_o_dat),
        .frame_cnt(s_frame_cnt), .drop_cnt(s_drop_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int exp_frame = 0;
    int exp_drop  = 0;
    logic       ev = 1'b0, ee = 1'b0;
    logic [3:0] ed = 4'h0;
    logic [7:0] hdr [14];
    logic [3:0] pay [$];

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    function automatic bit dest_ok();
`ifdef ETH_RX_MAC_FILTER_EN
        bit mac = 1'b1;
        bit bc  = 1'b1;
        for (int b = 0; b < 6; b++) begin
            if (hdr[b] != MAC_ADDR[47-8*b -: 8]) mac = 1'b0;
            if (hdr[b] != 8'hFF) bc = 1'b0;
        end
        return mac || bc;
`else
        return 1'b1;
`endif
    endfunction

    task automatic set_hdr(input logic [47:0] dest, input logic [15:0] et);
        for (int b = 0; b < 6; b++) hdr[b] = dest[47-8*b -: 8];
        for (int b = 6; b < 12; b++) hdr[b] = 8'($urandom);
        hdr[12] = et[15:8];
        hdr[13] = et[7:0];
    endtask

    task automatic set_pay_rand(input int n);
        pay = {};
        for (int i = 0; i < n; i++) pay.push_back(4'($urandom));
    endtask

    // One clock: drive inputs after the edge, then at the falling edge compare
    // outputs against the expectation recorded for the previous cycle's input.
    task automatic drive_cycle(input logic v, input logic e, input logic [3:0] d,
                               input logic xv, input logic xe, input logic [3:0] xd);
        @(posedge clk); #1;
        i_vld = v; i_eof = e; i_dat = d;
        @(negedge clk);
        tests++;
        if (o_vld !== ev || s_o_vld !== ev) begin
            fails++;
            $display("FAIL o_vld: got %b (sat %b) expected %b at %0t", o_vld, s_o_vld, ev, $time);
        end
        tests++;
        if (ev) begin
            if (o_dat !== ed || o_eof !== ee) begin
                fails++;
                $display("FAIL o_dat/o_eof: got %h/%b expected %h/%b at %0t", o_dat, o_eof, ed, ee, $time);
            end
        end else if (o_eof !== 1'b0) begin
            fails++;
            $display("FAIL o_eof idle: got %b expected 0 at %0t", o_eof, $time);
        end
        ev = xv; ee = xe; ed = xd;
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 1'($urandom), 4'($urandom), 1'b0, 1'b0, 4'h0);
    endtask

    task automatic check_counters(input string name);
        idle_cycle();
        tests++;
        if (frame_cnt !== 16'(exp_frame) || drop_cnt !== 16'(exp_drop)) begin
            fails++;
            $display("FAIL %s counters: got %0d/%0d expected %0d/%0d", name, frame_cnt, drop_cnt, exp_frame, exp_drop);
        end
        tests++;
        if (s_frame_cnt !== 2'(sat3(exp_frame)) || s_drop_cnt !== 2'(sat3(exp_drop))) begin
            fails++;
            $display("FAIL %s sat counters: got %0d/%0d expected %0d/%0d", name, s_frame_cnt, s_drop_cnt, sat3(exp_frame), sat3(exp_drop));
        end
    endtask

    // gap_mode: 0 none, 1 one idle before each nibble, 2 random 0..2 idles
    task automatic send_frame(input int runt_at, input int gap_mode);
        logic [3:0] nib [$];
        int  n;
        bit  acc;
        nib = {};
        for (int b = 0; b < 14; b++) begin
            nib.push_back(hdr[b][3:0]);
            nib.push_back(hdr[b][7:4]);
        end
        foreach (pay[i]) nib.push_back(pay[i]);
        if (runt_at >= 0)
            while (nib.size() > runt_at + 1) void'(nib.pop_back());
        n   = nib.size();
        acc = (n > 28) && hdr[12] == 8'h88 && hdr[13] == 8'hB5 && dest_ok();
        for (int i = 0; i < n; i++) begin
            if (gap_mode == 1) idle_cycle();
            else if (gap_mode == 2) repeat ($urandom_range(0, 2)) idle_cycle();
            drive_cycle(1'b1, i == n - 1, nib[i], acc && i >= 28, acc && i == n - 1, nib[i]);
        end
        if (acc) exp_frame++;
        else     exp_drop++;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; i_vld = 1'b0; i_eof = 1'b0; i_dat = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_frame = 0; exp_drop = 0;
        ev = 1'b0; ee = 1'b0; ed = 4'h0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (o_vld !== 1'b0 || o_eof !== 1'b0 || o_dat !== 4'h0) begin
            fails++;
            $display("FAIL reset outputs: got %b/%b/%h expected 0/0/0", o_vld, o_eof, o_dat);
        end
        check_counters("reset");
    endtask

    task automatic test_basic();
        do_reset();
        set_hdr(MAC_ADDR, 16'h88B5);
        pay = {};
        for (int i = 1; i <= 8; i++) pay.push_back(4'(i));
        send_frame(-1, 0);
        check_counters("basic");
    endtask

    task automatic test_bad_ethertype();
        do_reset();
        set_hdr(MAC_ADDR, 16'h0800);
        set_pay_rand(8);
        send_frame(-1, 0);
        check_counters("ethertype_drop");
        set_hdr(MAC_ADDR, 16'h88B5);
        set_pay_rand(6);
        send_frame(-1, 0);
        check_counters("ethertype_after");
    endtask

    task automatic test_runts();
        do_reset();
        set_hdr(MAC_ADDR, 16'h88B5);
        set_pay_rand(5);
        send_frame(10, 0);
        send_frame(27, 0);
        check_counters("runts");
        pay = {};
        send_frame(-1, 0);
        set_pay_rand(3);
        send_frame(-1, 0);
        check_counters("runt_zero_payload");
    endtask

    task automatic test_gaps();
        do_reset();
        set_hdr(MAC_ADDR, 16'h88B5);
        pay = {4'hA, 4'hB, 4'hC, 4'hD};
        send_frame(-1, 1);
        check_counters("gaps");
        set_pay_rand(7);
        send_frame(-1, 2);
        check_counters("gaps_random");
    endtask

    task automatic test_reset_mid_payload();
        logic [3:0] nib [$];
        do_reset();
        set_hdr(MAC_ADDR, 16'h88B5);
        nib = {};
        for (int b = 0; b < 14; b++) begin
            nib.push_back(hdr[b][3:0]);
            nib.push_back(hdr[b][7:4]);
        end
        for (int i = 0; i < 3; i++) nib.push_back(4'(i + 5));
        foreach (nib[i]) drive_cycle(1'b1, 1'b0, nib[i], i >= 28, 1'b0, nib[i]);
        @(posedge clk); #1;
        rst = 1'b1; i_vld = 1'b0;
        #1;
        tests++;
        if (o_vld !== 1'b0 || frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_mid_payload: got vld %b cnt %0d/%0d expected 0 0/0", o_vld, frame_cnt, drop_cnt);
        end
        ev = 1'b0; ee = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_frame = 0; exp_drop = 0;
        set_pay_rand(5);
        send_frame(-1, 0);
        check_counters("after_reset_mid");
    endtask

    task automatic test_mac_filter();
        do_reset();
        set_hdr(MAC_ADDR, 16'h88B5); set_pay_rand(4); send_frame(-1, 0);
        set_hdr(BCAST,    16'h88B5); set_pay_rand(4); send_frame(-1, 0);
        set_hdr(MAC_BAD,  16'h88B5); set_pay_rand(4); send_frame(-1, 0);
        check_counters("mac_filter");
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_hdr(MAC_ADDR, 16'h0800);
            set_pay_rand(3);
            send_frame(-1, 0);
        end
        check_counters("saturation");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_hdr(MAC_ADDR, (k == 2) ? 16'h88B4 : 16'h88B5);
            set_pay_rand(2 + k);
            send_frame(-1, 0);
        end
        check_counters("back_to_back");
    endtask

    task automatic test_random();
        logic [47:0] dest;
        logic [15:0] et;
        int sel;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       dest = MAC_ADDR;
                1:       dest = BCAST;
                2:       dest = {$urandom, 16'($urandom)};
                default: dest = MAC_ADDR ^ (48'd1 << $urandom_range(0, 47));
            endcase
            sel = $urandom_range(0, 3);
            if (sel < 2)       et = 16'h88B5;
            else if (sel == 2) et = 16'($urandom);
            else               et = 16'h88B5 ^ (16'd1 << $urandom_range(0, 15));
            set_hdr(dest, et);
            set_pay_rand($urandom_range(1, 12));
            send_frame(($urandom_range(0, 4) == 0) ? $urandom_range(0, 27) : -1, $urandom_range(0, 2));
            if (k % 8 == 7) check_counters("random");
        end
        check_counters("random_end");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_ethertype();
        test_runts();
        test_gaps();
        test_reset_mid_payload();
        test_mac_filter();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
